tinyqv_data_responder: RTL and testbench

- Nibble-serial data-memory responder that sits on the far side of the core's load/store port.
- Stores: captures the core's store-data nibble stream and commits it on `address_ready`, honouring byte and half write masks.
- Loads: returns read data as an 8-nibble stream with `load_data_ready`, aligned to the shared `counter` phase, after a configurable number of 8-clock windows.
- Provides a small word-addressed RAM for bring-up and peripheral modelling behind the core.

---
 rtl/tinyqv_mem_pkg.sv | 62 ++++++
 rtl/tinyqv_data_ram.sv | 25 ++
 rtl/tinyqv_data_responder.sv | 148 ++++++++++++++
 tb/tb_tinyqv_data_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tinyqv_mem_pkg.sv
// Shared load/store definitions for the TinyQV data responder.
// Covers mem_op encodings, lane masks and the byte rotator.
package tinyqv_mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } rd_state_t;

  // Byte-lane enables for a store of size op at byte offset a.
  function automatic logic [3:0] lane_mask(
    input logic [1:0] op,
    input logic [1:0] a
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      op == MEM_BYTE: m = 4'b0001 << a;
      op == MEM_HALF: m = a[1] ? 4'b1100 : 4'b0011;
      op == MEM_WORD: m = 4'b1111;
      default:        m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate the low byte/half so any enabled lane sees it.
  function automatic logic [31:0] lane_data(
    input logic [1:0]  op,
    input logic [31:0] w
  );
    logic [31:0] d;
    d = w;
    unique case (1'b1)
      op == MEM_BYTE: d = {4{w[7:0]}};
      op == MEM_HALF: d = {2{w[15:0]}};
      default:        d = w;
    endcase
    return d;
  endfunction

  // Rotate a word right by whole bytes.
  function automatic logic [31:0] rotr_bytes(
    input logic [31:0] w,
    input logic [1:0]  n
  );
    logic [31:0] r;
    r = w;
    unique case (1'b1)
      n == 2'd1: r = {w[7:0],  w[31:8]};
      n == 2'd2: r = {w[15:0], w[31:16]};
      n == 2'd3: r = {w[23:0], w[31:24]};
      default:   r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tinyqv_data_ram.sv
// Word-addressed RAM with byte-lane write enables.
// Combinational read; contents are never reset.
module tinyqv_data_ram #(
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_BITS];

  // Per-lane writes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tinyqv_data_responder.sv
// Nibble-serial data responder behind the TinyQV load/store port.
// Captures store nibbles, commits them and streams load windows.
module tinyqv_data_responder
  import tinyqv_mem_pkg::*;
#(
  parameter int          DEPTH_BITS   = 4,
  parameter logic [23:0] BASE         = 24'h000000,
  parameter int          LOAD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  counter,
  input  logic [27:0] addr,
  input  logic        address_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [3:0]  store_data,
  output logic        load_data_ready,
  output logic [3:0]  load_data,
  output logic        busy,
  output logic        decode_miss
);

  localparam int HI_W = 26 - DEPTH_BITS;
  localparam logic [HI_W-1:0] BASE_HI = BASE[HI_W-1:0];
  localparam logic [2:0] WAIT_INIT = 3'(LOAD_LATENCY - 1);

  rd_state_t state_q, state_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic [DEPTH_BITS-1:0] idx_q;
  logic [1:0]            lane_q;
  logic                  sel_q;
  logic [31:0]           resp_q;
  logic [27:0]           shreg_q;
  logic                  miss_q;

  logic [31:0]           st_word;
  logic                  hit;
  logic                  at_end;
  logic                  free;
  logic                  take;
  logic                  do_store;
  logic                  do_load;
  logic                  fetch;
  logic                  fetch_sel;
  logic [1:0]            fetch_lane;
  logic [DEPTH_BITS-1:0] a_idx;
  logic [DEPTH_BITS-1:0] raddr;
  logic [3:0]            we;
  logic [31:0]           rdata;
  logic                  unused_mem_op;

  assign unused_mem_op = mem_op[2];

  assign st_word  = {store_data, shreg_q};
  assign a_idx    = addr[DEPTH_BITS+1:2];
  assign hit      = addr[27:DEPTH_BITS+2] == BASE_HI;
  assign at_end   = counter == 3'd7;
  // The cycle that ends a response window can already accept the next access.
  assign free     = (state_q == ST_IDLE) ||
                    (state_q == ST_RESP && at_end);
  assign take     = address_ready && free;
  assign do_store = take && is_store;
  assign do_load  = take && is_load && !is_store;

  // With a one-window latency the accept cycle is itself the fetch cycle.
  assign fetch = (do_load && WAIT_INIT == 3'd0) ||
                 (state_q == ST_WAIT && at_end && wcnt_q == 3'd0);

  assign fetch_sel  = do_load ? hit       : sel_q;
  assign fetch_lane = do_load ? addr[1:0] : lane_q;
  assign raddr      = do_load ? a_idx     : idx_q;

  assign we = (do_store && hit) ? lane_mask(mem_op[1:0], addr[1:0])
                                : 4'b0000;

  tinyqv_data_ram #(
    .DEPTH_BITS(DEPTH_BITS)
  ) u_ram (
    .clk  (clk),
    .waddr(a_idx),
    .we   (we),
    .wdata(lane_data(mem_op[1:0], st_word)),
    .raddr(raddr),
    .rdata(rdata)
  );

  // Read sequencing: next state and latency countdown.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_WAIT: begin
        if (at_end) begin
          if (wcnt_q == 3'd0) state_d = ST_RESP;
          else                wcnt_d  = wcnt_q - 3'd1;
        end
      end
      ST_RESP: if (at_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (do_load) begin
      if (WAIT_INIT == 3'd0) begin
        state_d = ST_RESP;
        wcnt_d  = 3'd0;
      end else begin
        state_d = ST_WAIT;
        wcnt_d  = WAIT_INIT - 3'd1;
      end
    end
  end

  // State, request latch, response word, store shifter, sticky miss.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 3'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      sel_q   <= 1'b0;
      resp_q  <= 32'd0;
      shreg_q <= 28'd0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      shreg_q <= {store_data, shreg_q[27:4]};
      if (do_load) begin
        idx_q  <= a_idx;
        lane_q <= addr[1:0];
        sel_q  <= hit;
      end
      if (fetch) begin
        resp_q <= fetch_sel ? rotr_bytes(rdata, fetch_lane) : 32'd0;
      end
      if ((do_store || do_load) && !hit) miss_q <= 1'b1;
    end
  end

  assign load_data_ready = state_q == ST_RESP;
  assign load_data       = load_data_ready ? resp_q[{counter, 2'b00} +: 4]
                                           : 4'd0;
  assign busy            = state_q != ST_IDLE;
  assign decode_miss     = miss_q;

endmodule

// File: tb/tb_tinyqv_data_responder.sv
// Directed bench for tinyqv_data_responder.
// Table of 8-clock windows plus latency and reset sequences.
module tb_tinyqv_data_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [2:0]  counter = 3'd0;
  logic [27:0] addr = 28'd0;
  logic        ar1 = 1'b0;
  logic        ar3 = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  mem_op = 3'd0;
  logic [3:0]  store_data = 4'd0;

  logic        rdy1, rdy3, busy1, busy3, miss1, miss3;
  logic [3:0]  ld1, ld3;

  always #5 clk = ~clk;

  tinyqv_data_responder #(
    .DEPTH_BITS(4), .BASE(24'h000000), .LOAD_LATENCY(1)
  ) u1 (
    .clk(clk), .rstn(rstn), .counter(counter), .addr(addr),
    .address_ready(ar1), .is_load(is_load), .is_store(is_store),
    .mem_op(mem_op), .store_data(store_data),
    .load_data_ready(rdy1), .load_data(ld1),
    .busy(busy1), .decode_miss(miss1)
  );

  tinyqv_data_responder #(
    .DEPTH_BITS(4), .BASE(24'h000000), .LOAD_LATENCY(3)
  ) u3 (
    .clk(clk), .rstn(rstn), .counter(counter), .addr(addr),
    .address_ready(ar3), .is_load(is_load), .is_store(is_store),
    .mem_op(mem_op), .store_data(store_data),
    .load_data_ready(rdy3), .load_data(ld3),
    .busy(busy3), .decode_miss(miss3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit          en1, en3;
  logic [7:0]  w_rdy1, w_rdy3;
  logic [31:0] w_dat1, w_dat3;
  logic        w_miss1, w_busy1, w_busy3;

  typedef struct {
    logic        ar, ld, st;
    logic [27:0] a;
    logic [1:0]  op;
    logic [31:0] wd;
    logic [7:0]  erdy;
    logic [31:0] edat;
    logic        emiss;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t v(
    input logic ar, ld, st,
    input logic [27:0] a, input logic [1:0] op,
    input logic [31:0] wd, input logic [7:0] erdy,
    input logic [31:0] edat, input logic emiss
  );
    vec_t r;
    r.ar = ar; r.ld = ld; r.st = st; r.a = a; r.op = op;
    r.wd = wd; r.erdy = erdy; r.edat = edat; r.emiss = emiss;
    return r;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One 8-clock window; access (if any) is presented at counter 7.
  task automatic window(input logic ar, ld, st,
                        input logic [27:0] a, input logic [1:0] op,
                        input logic [31:0] wd);
    for (int i = 0; i < 8; i++) begin
      counter    = 3'(i);
      store_data = wd[4*i +: 4];
      addr       = a;
      mem_op     = {1'b0, op};
      is_load    = ld;
      is_store   = st;
      ar1        = en1 && ar && (i == 7);
      ar3        = en3 && ar && (i == 7);
      #2;
      if (i == 0) begin
        w_miss1 = miss1;
        w_busy1 = busy1;
        w_busy3 = busy3;
      end
      w_rdy1[i] = rdy1;
      w_rdy3[i] = rdy3;
      w_dat1[4*i +: 4] = ld1;
      w_dat3[4*i +: 4] = ld3;
      @(posedge clk);
      #1;
    end
    ar1 = 1'b0;
    ar3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    en1 = 1'b1;
    en3 = 1'b0;
    #1 rstn = 1'b0;
    @(posedge clk);
    #3;
    check("rst_rdy",  {31'd0, rdy1},  32'd0);
    check("rst_data", {28'd0, ld1},   32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_miss", {31'd0, miss1}, 32'd0);
    check("rst_busy3", {31'd0, busy3}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;

    tbl[0]  = v(1,0,1, 28'h08, 2'b10, 32'hDEADBEEF, 8'h00, 32'h0, 0);
    tbl[1]  = v(1,1,0, 28'h08, 2'b10, 32'h0,        8'h00, 32'h0, 0);
    tbl[2]  = v(0,0,0, 28'h00, 2'b10, 32'h0,        8'hFF, 32'hDEADBEEF, 0);
    tbl[3]  = v(1,0,1, 28'h0A, 2'b00, 32'h0000005A, 8'h00, 32'h0, 0);
    tbl[4]  = v(1,0,1, 28'h08, 2'b01, 32'h00001234, 8'h00, 32'h0, 0);
    tbl[5]  = v(1,1,0, 28'h08, 2'b10, 32'h0,        8'h00, 32'h0, 0);
    tbl[6]  = v(1,1,0, 28'h0B, 2'b00, 32'h0,        8'hFF, 32'hDE5A1234, 0);
    tbl[7]  = v(0,0,0, 28'h00, 2'b10, 32'h0,        8'hFF, 32'h5A1234DE, 0);
    tbl[8]  = v(1,0,1, 28'h0B, 2'b01, 32'h0000CAFE, 8'h00, 32'h0, 0);
    tbl[9]  = v(1,1,0, 28'h08, 2'b10, 32'h0,        8'h00, 32'h0, 0);
    tbl[10] = v(0,0,0, 28'h00, 2'b10, 32'h0,        8'hFF, 32'hCAFE1234, 0);
    tbl[11] = v(1,0,1, 28'h0F, 2'b10, 32'h01234567, 8'h00, 32'h0, 0);
    tbl[12] = v(1,1,0, 28'h0E, 2'b10, 32'h0,        8'h00, 32'h0, 0);
    tbl[13] = v(0,0,0, 28'h00, 2'b10, 32'h0,        8'hFF, 32'h45670123, 0);
    tbl[14] = v(1,1,0, 28'h48, 2'b10, 32'h0,        8'h00, 32'h0, 0);
    tbl[15] = v(0,0,0, 28'h00, 2'b10, 32'h0,        8'hFF, 32'h00000000, 1);
    tbl[16] = v(1,0,1, 28'h48, 2'b10, 32'h11111111, 8'h00, 32'h0, 1);
    tbl[17] = v(1,1,0, 28'h08, 2'b10, 32'h0,        8'h00, 32'h0, 1);
    tbl[18] = v(0,0,0, 28'h00, 2'b10, 32'h0,        8'hFF, 32'hCAFE1234, 1);
    tbl[19] = v(1,1,1, 28'h04, 2'b10, 32'hA5A5A5A5, 8'h00, 32'h0, 1);
    tbl[20] = v(0,0,0, 28'h00, 2'b10, 32'h0,        8'h00, 32'h0, 1);
    tbl[21] = v(1,1,0, 28'h04, 2'b10, 32'h0,        8'h00, 32'h0, 1);
    tbl[22] = v(0,0,0, 28'h00, 2'b10, 32'h0,        8'hFF, 32'hA5A5A5A5, 1);
    tbl[23] = v(1,0,0, 28'h04, 2'b10, 32'h0,        8'h00, 32'h0, 1);
    tbl[24] = v(1,1,0, 28'h04, 2'b10, 32'h0,        8'h00, 32'h0, 1);
    tbl[25] = v(0,0,0, 28'h00, 2'b10, 32'h0,        8'hFF, 32'hA5A5A5A5, 1);

    for (int k = 0; k < 26; k++) begin
      window(tbl[k].ar, tbl[k].ld, tbl[k].st,
             tbl[k].a, tbl[k].op, tbl[k].wd);
      check($sformatf("vec%0d_rdy", k), {24'd0, w_rdy1}, {24'd0, tbl[k].erdy});
      if (tbl[k].erdy != 8'h00)
        check($sformatf("vec%0d_data", k), w_dat1, tbl[k].edat);
      check($sformatf("vec%0d_miss", k), {31'd0, w_miss1}, {31'd0, tbl[k].emiss});
    end

    // Latency 3 on u3 with a store attempted while waiting.
    en1 = 1'b0;
    en3 = 1'b1;
    window(1,0,1, 28'h00, 2'b10, 32'h0BADF00D);
    window(1,1,0, 28'h00, 2'b10, 32'h0);
    window(1,0,1, 28'h00, 2'b10, 32'hFFFFFFFF);
    check("lat_w1_busy", {31'd0, w_busy3}, 32'd1);
    check("lat_w1_rdy",  {24'd0, w_rdy3},  32'd0);
    window(0,0,0, 28'h00, 2'b10, 32'h0);
    check("lat_w2_busy", {31'd0, w_busy3}, 32'd1);
    check("lat_w2_rdy",  {24'd0, w_rdy3},  32'd0);
    window(0,0,0, 28'h00, 2'b10, 32'h0);
    check("lat_w3_busy", {31'd0, w_busy3}, 32'd1);
    check("lat_w3_rdy",  {24'd0, w_rdy3},  32'h0000_00FF);
    check("lat_w3_data", w_dat3, 32'h0BADF00D);
    window(0,0,0, 28'h00, 2'b10, 32'h0);
    check("lat_w4_busy", {31'd0, w_busy3}, 32'd0);
    check("lat_w4_rdy",  {24'd0, w_rdy3},  32'd0);

    // Reset in the middle of a response window on u1.
    en1 = 1'b1;
    en3 = 1'b0;
    window(1,0,1, 28'h00, 2'b10, 32'h76543210);
    window(1,1,0, 28'h00, 2'b10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      counter = 3'(i);
      is_load = 1'b0;
      is_store = 1'b0;
      #2;
      check($sformatf("mid_rdy%0d", i), {31'd0, rdy1}, 32'd1);
      check($sformatf("mid_nib%0d", i), {28'd0, ld1}, 32'(i));
      if (i == 3) begin
        rstn = 1'b0;
        #1;
        check("mid_rst_rdy",  {31'd0, rdy1},  32'd0);
        check("mid_rst_busy", {31'd0, busy1}, 32'd0);
        check("mid_rst_data", {28'd0, ld1},   32'd0);
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    window(1,1,0, 28'h00, 2'b10, 32'h0);
    check("post_rst_miss", {31'd0, w_miss1}, 32'd0);
    window(0,0,0, 28'h00, 2'b10, 32'h0);
    check("post_rst_rdy",  {24'd0, w_rdy1}, 32'h0000_00FF);
    check("post_rst_data", w_dat1, 32'h76543210);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
